// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// It drives the PC, IF/ID and ID/EX write-enable and flush controls.
// It tracks a fixed-latency multiply/divide unit, and keeps saturating
// stall and flush event counters for performance debug.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | MDU idle; mult/div ops may be accepted from ID
// MDU_BUSY | MDU executing; mcnt counts down the remaining busy cycles
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_mdu_op,
  input  logic             id_hilo_read,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] mcnt, mcnt_nxt;
  logic       load_use, mdu_hazard, stall;

  // Hazard detection; register $0 never creates a load-use dependency.
  always_comb begin
    load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdu_hazard = (state == MDU_BUSY) && (id_mdu_op || id_hilo_read);
    stall      = load_use || mdu_hazard;
  end

  // Pipeline controls. A taken branch outranks a stall because the stalled
  // instruction is on the wrong path. A jump held by a stall is flushed only
  // once the stall clears. Everything is quiet while reset is asserted.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Next-state logic. An issued MDU op always runs to completion; a later
  // branch does not cancel it.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    case (state)
      RUN: begin
        if (id_mdu_op && !ex_branch_taken && !stall) begin
          state_nxt = MDU_BUSY;
          mcnt_nxt  = 8'(MDU_LAT);
        end
      end
      MDU_BUSY: begin
        if (mcnt == 8'd1) begin
          state_nxt = RUN;
          mcnt_nxt  = 8'd0;
        end else begin
          mcnt_nxt = mcnt - 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        mcnt_nxt  = 8'd0;
      end
    endcase
  end

  // State register and MDU down-counter; reset aborts any countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      mcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  assign mdu_busy = (state == MDU_BUSY);

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ifid_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF/ID and ID/EX registers. It resolves load-use stalls, taken-branch and jump flushes, and structural/HI-LO stalls around a fixed-latency multiply/divide unit (MDU). It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- MDU_LAT, 4: MDU busy cycles per mult/div op; legal range 2..255.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- id_jump  in  1  the ID instruction is j/jal/jr.
- id_mdu_op  in  1  the ID instruction is mult/multu/div/divu.
- id_hilo_read  in  1  the ID instruction is mfhi/mflo.
- ex_mem_read  in  1  the instruction in ID/EX is a load.
- ex_rt  in  5  destination register of that load.
- ex_branch_taken  in  1  a branch resolved taken in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable; 0 holds its contents.
- ifid_flush  out  1  IF/ID clears to a nop on the next edge.
- idex_flush  out  1  ID/EX loads a bubble on the next edge.
- mdu_busy  out  1  the MDU is executing.
- stall_cnt  out  CNT_W  cycles with ifid_write=0.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.

## Operation
- State machine: RUN and MDU_BUSY. There is also a down-counter, mcnt, of 8 bits.
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- mdu_hazard = (state == MDU_BUSY) & (id_mdu_op | id_hilo_read).
- stall = load_use | mdu_hazard.
- Output priority, highest first:
  1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. This applies even when stall is true, because the stalled instruction is on the wrong path.
  2. stall: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  3. id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- A jump held in ID by a stall gets its flush only in the first non-stalled cycle.
- MDU acceptance: an op is accepted when state==RUN, id_mdu_op=1, ex_branch_taken=0 and stall=0.
  - On the edge that accepts it: state goes to MDU_BUSY and mcnt is loaded with MDU_LAT.
- In MDU_BUSY, on each edge:
  - If mcnt==1: state goes to RUN and mcnt to 0.
  - Otherwise mcnt decrements by 1.
  - ex_branch_taken does not cancel the countdown, because the op has already issued.
- mdu_busy = (state == MDU_BUSY).
- Counters:
  - stall_cnt increments on every edge where ifid_write=0.
  - flush_cnt increments on every edge where ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (reset=0):
  - state=RUN, mcnt=0, stall_cnt=0, flush_cnt=0.
  - While reset is held: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, mdu_busy=0.
  - Reset in the middle of an MDU countdown aborts it immediately.

## Timing
- pc_write, ifid_write, ifid_flush and idex_flush are combinational from the inputs and the registered state, with zero-cycle latency.
- mdu_busy, stall_cnt and flush_cnt are registered, or decoded directly from registered state.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load has moved to EX/MEM, so load_use drops.
- MDU op accepted in cycle t: mdu_busy=1 for cycles t+1 .. t+MDU_LAT. A dependent mfhi/mflo in ID first proceeds in cycle t+MDU_LAT+1.
- Back-to-back MDU ops: the second op stalls in ID until state==RUN. It is accepted in cycle t+MDU_LAT+1.
- Reset deassertion is asynchronous to clk at the block boundary. The first state change can occur on the first rising edge after reset goes high.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle. Required: pc_write=0, ifid_write=0, idex_flush=1 that cycle, and stall_cnt 0 -> 1.
- Register $0 and unused rt:
  - ex_rt=0 with id_rs=0: no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0: no stall.
- MDU with MDU_LAT=4:
  - mult accepted in cycle 0.
  - mdu_busy=1 in cycles 1-4.
  - mfhi presented in ID from cycle 1: stalled in cycles 1-4, proceeds in cycle 5.
  - stall_cnt=4 at the end.
- Branch beats stall: load_use=1 and ex_branch_taken=1 in the same cycle. Required: pc_write=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged, flush_cnt +1.
- Jump under stall: id_jump=1 with load_use=1. Required: ifid_flush=0 that cycle, then ifid_flush=1 in the next cycle.
- Reset mid-MDU: at mcnt=2, drive reset=0. Required: mdu_busy=0 immediately and all counters 0. After release, a new mult is accepted and mdu_busy rises on the next cycle.
